mem_stage: RTL and testbench

//  Memory pipeline stage between EXE and WB.
//  - Holds one instruction and waits for the data-SRAM response (data_ok) of a request that EXE issued.
//  - Aligns and extends load data, then forwards the result and pass-through fields to WB on MEM_to_WB_bus.
//  - Drops responses that belong to instructions killed by exec_flush, so late data never reaches a younger instruction.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_load_align.sv | 30 +++
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, ld_op bit indices and bus field offsets for the MEM stage.
package mem_pkg;
  localparam int PASS_W = 186;
  localparam int E2M_W  = PASS_W + 45;
  localparam int M2W_W  = PASS_W + 38;
  localparam int M2ID_W = 39;

  // ld_op is one-hot {w,hu,h,bu,b}
  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  // EXE->MEM bus: {pass, gr_we, dest, mem_req, ld_op, ex_any, alu_result}
  localparam int E_ALU_LSB  = 0;
  localparam int E_EX_ANY   = 32;
  localparam int E_LD_LSB   = 33;
  localparam int E_MEM_REQ  = 38;
  localparam int E_DEST_LSB = 39;
  localparam int E_GR_WE    = 44;
  localparam int E_PASS_LSB = 45;

  // MEM->WB bus: {pass, gr_we, dest, final_result}
  localparam int W_RES_LSB  = 0;
  localparam int W_DEST_LSB = 32;
  localparam int W_GR_WE    = 37;
  localparam int W_PASS_LSB = 38;
endpackage

// File: rtl/mem_load_align.sv
// Combinational load alignment: shifts the SRAM word by the byte offset, then sign/zero extends.
// Zero latency, no handshake; offsets are assumed legal for the access size.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [4:0]  ld_op,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    if (ld_op[LD_W]) begin
      result = rdata;
    end else if (ld_op[LD_H]) begin
      result = {{16{shifted[15]}}, shifted[15:0]};
    end else if (ld_op[LD_HU]) begin
      result = {16'h0000, shifted[15:0]};
    end else if (ld_op[LD_B]) begin
      result = {{24{shifted[7]}}, shifted[7:0]};
    end else if (ld_op[LD_BU]) begin
      result = {24'h000000, shifted[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction until its data-SRAM response, 1 cycle for non-memory ops.
// Stalls EXE via MEM_allowin when waiting or when WB backpressures; responses of flushed requests are dropped.
module mem_stage #(
  parameter int PASS_W = 186
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EXE_to_MEM_valid,
  input  logic [PASS_W+44:0] EXE_to_MEM_bus,
  input  logic              EXE_req_accepted,
  output logic              MEM_allowin,
  input  logic              WB_allowin,
  output logic              MEM_to_WB_valid,
  output logic [PASS_W+37:0] MEM_to_WB_bus,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              exec_flush,
  output logic [38:0]       MEM_to_ID_bus,
  output logic              out_MEM_valid
);
  import mem_pkg::*;

  logic               mem_valid_q, mem_valid_d;
  logic [PASS_W+44:0] bus_q, bus_d;
  logic               data_got_q, data_got_d;
  logic [31:0]        rdata_buf_q, rdata_buf_d;
  logic [1:0]         cancel_cnt_q, cancel_cnt_d;

  logic [31:0]        alu_result;
  logic               ex_any, mem_req, gr_we, is_load;
  logic [4:0]         ld_op, dest;
  logic [PASS_W-1:0]  pass;
  logic               resp_ok, ready_go;
  logic [31:0]        align_in, load_result, final_result;
  logic               fwd_we, fwd_wait;
  logic               cnt_dec;
  logic [1:0]         cnt_inc;
  logic [2:0]         cnt_sum;

  assign alu_result = bus_q[E_ALU_LSB +: 32];
  assign ex_any     = bus_q[E_EX_ANY];
  assign ld_op      = bus_q[E_LD_LSB +: 5];
  assign mem_req    = bus_q[E_MEM_REQ];
  assign dest       = bus_q[E_DEST_LSB +: 5];
  assign gr_we      = bus_q[E_GR_WE];
  assign pass       = bus_q[E_PASS_LSB +: PASS_W];
  assign is_load    = |ld_op;

  // A response only belongs to the current instruction once all cancelled ones have drained.
  assign resp_ok  = data_sram_data_ok & (cancel_cnt_q == 2'd0);
  assign ready_go = !mem_req | data_got_q | resp_ok;

  assign MEM_allowin     = !mem_valid_q | (ready_go & WB_allowin);
  assign MEM_to_WB_valid = mem_valid_q & ready_go & !exec_flush;
  assign out_MEM_valid   = mem_valid_q;

  assign align_in = data_got_q ? rdata_buf_q : data_sram_rdata;

  mem_load_align u_align (
    .rdata  (align_in),
    .offset (alu_result[1:0]),
    .ld_op  (ld_op),
    .result (load_result)
  );

  assign final_result = is_load ? load_result : alu_result;
  assign fwd_we       = mem_valid_q & gr_we;
  assign fwd_wait     = fwd_we & is_load & !(data_got_q | resp_ok);

  assign MEM_to_WB_bus = {pass, gr_we, dest, final_result};
  assign MEM_to_ID_bus = {fwd_we, fwd_wait, dest, final_result};

  always_comb begin
    mem_valid_d = mem_valid_q;
    if (exec_flush) begin
      mem_valid_d = 1'b0;
    end else if (MEM_allowin) begin
      mem_valid_d = EXE_to_MEM_valid;
    end

    bus_d = bus_q;
    if (MEM_allowin && EXE_to_MEM_valid) begin
      bus_d = EXE_to_MEM_bus;
    end

    data_got_d  = data_got_q;
    rdata_buf_d = rdata_buf_q;
    if (exec_flush || (mem_valid_q && ready_go && WB_allowin)) begin
      data_got_d = 1'b0;
    end else if (mem_valid_q && mem_req && resp_ok && !data_got_q) begin
      data_got_d  = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
  end

  // Decrement for a dropped response is applied before the flush increment.
  always_comb begin
    cnt_dec = data_sram_data_ok & (cancel_cnt_q != 2'd0);
    cnt_inc = 2'd0;
    if (exec_flush) begin
      cnt_inc = {1'b0, mem_valid_q & mem_req & !data_got_q & !resp_ok} + {1'b0, EXE_req_accepted};
    end
    cnt_sum      = {1'b0, cancel_cnt_q} - {2'b00, cnt_dec} + {1'b0, cnt_inc};
    cancel_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q  <= 1'b0;
      bus_q        <= '0;
      data_got_q   <= 1'b0;
      rdata_buf_q  <= 32'h0;
      cancel_cnt_q <= 2'd0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      bus_q        <= bus_d;
      data_got_q   <= data_got_d;
      rdata_buf_q  <= rdata_buf_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  a_cancel_no_overflow: assert property (@(posedge clk) disable iff (reset) cnt_sum <= 3'd3);
  a_ex_has_no_mem_req:  assert property (@(posedge clk) disable iff (reset) !(mem_valid_q && ex_any && mem_req));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: alignment vector table plus stall, buffer, flush and reset sequences.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int PW = 186;
  localparam logic [PW-1:0] PASS_PAT = {2'b10, {23{8'hA5}}};
  localparam logic [4:0] OP_B = 5'b00001, OP_BU = 5'b00010, OP_H = 5'b00100,
                         OP_HU = 5'b01000, OP_W = 5'b10000, OP_N = 5'b00000;

  logic            clk;
  logic            reset;
  logic            EXE_to_MEM_valid;
  logic [PW+44:0]  EXE_to_MEM_bus;
  logic            EXE_req_accepted;
  logic            MEM_allowin;
  logic            WB_allowin;
  logic            MEM_to_WB_valid;
  logic [PW+37:0]  MEM_to_WB_bus;
  logic            data_sram_data_ok;
  logic [31:0]     data_sram_rdata;
  logic            exec_flush;
  logic [38:0]     MEM_to_ID_bus;
  logic            out_MEM_valid;

  int checks = 0;
  int errors = 0;

  mem_stage #(.PASS_W(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .EXE_to_MEM_valid  (EXE_to_MEM_valid),
    .EXE_to_MEM_bus    (EXE_to_MEM_bus),
    .EXE_req_accepted  (EXE_req_accepted),
    .MEM_allowin       (MEM_allowin),
    .WB_allowin        (WB_allowin),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .MEM_to_WB_bus     (MEM_to_WB_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .exec_flush        (exec_flush),
    .MEM_to_ID_bus     (MEM_to_ID_bus),
    .out_MEM_valid     (out_MEM_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  typedef struct {
    logic [4:0]  ld_op;
    logic        mem_req;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [PW+44:0] mk(input logic gr_we, input logic [4:0] dest,
                                        input logic mem_req, input logic [4:0] ld_op,
                                        input logic [31:0] alu);
    return {PASS_PAT, gr_we, dest, mem_req, ld_op, 1'b0, alu};
  endfunction

  // Offers one instruction to MEM and returns one cycle later with it held in MEM.
  task automatic enter(input string name, input logic [PW+44:0] bus);
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus   = bus;
    settle();
    chk({name, "_allowin"}, MEM_allowin, 1'b1);
    tick();
    EXE_to_MEM_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{OP_N,  1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[1] = '{OP_B,  1'b1, 32'h0000_1003, 32'h80AA_BBCC, 32'hFFFF_FF80};
    vecs[2] = '{OP_BU, 1'b1, 32'h0000_1003, 32'h80AA_BBCC, 32'h0000_0080};
    vecs[3] = '{OP_B,  1'b1, 32'h0000_1000, 32'h80AA_BBCC, 32'hFFFF_FFCC};
    vecs[4] = '{OP_BU, 1'b1, 32'h0000_1001, 32'h80AA_BBCC, 32'h0000_00BB};
    vecs[5] = '{OP_H,  1'b1, 32'h0000_1002, 32'h80AA_BBCC, 32'hFFFF_80AA};
    vecs[6] = '{OP_HU, 1'b1, 32'h0000_1002, 32'h80AA_BBCC, 32'h0000_80AA};
    vecs[7] = '{OP_H,  1'b1, 32'h0000_1000, 32'h1234_7FFE, 32'h0000_7FFE};
    vecs[8] = '{OP_W,  1'b1, 32'h0000_1000, 32'h80AA_BBCC, 32'h80AA_BBCC};
    vecs[9] = '{OP_N,  1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000};

    reset = 1'b1; EXE_to_MEM_valid = 1'b0; EXE_to_MEM_bus = '0; EXE_req_accepted = 1'b0;
    WB_allowin = 1'b1; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; exec_flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_allowin", MEM_allowin, 1'b1);
    chk("rst_wb_valid", MEM_to_WB_valid, 1'b0);
    chk("rst_mem_valid", out_MEM_valid, 1'b0);
    chk("rst_fwd_flags", MEM_to_ID_bus[38:37], 2'b00);

    // Table: each entry enters, gets an immediate response (if a memory op) and leaves in one cycle.
    for (int i = 0; i < 10; i++) begin
      logic gw;
      gw = !(vecs[i].mem_req && vecs[i].ld_op == OP_N);
      enter($sformatf("v%0d", i), mk(gw, 5'd7, vecs[i].mem_req, vecs[i].ld_op, vecs[i].alu));
      data_sram_data_ok = vecs[i].mem_req;
      data_sram_rdata   = vecs[i].rdata;
      settle();
      chk($sformatf("v%0d_wb_valid", i), MEM_to_WB_valid, 1'b1);
      chk($sformatf("v%0d_result", i), MEM_to_WB_bus[31:0], vecs[i].exp);
      chk($sformatf("v%0d_fwd_we", i), MEM_to_ID_bus[38], gw);
      chk($sformatf("v%0d_fwd_wait", i), MEM_to_ID_bus[37], 1'b0);
      if (i == 0) chk("v0_pass_dest", MEM_to_WB_bus[PW+37:32], {PASS_PAT, 1'b1, 5'd7});
      tick();
      data_sram_data_ok = 1'b0;
      settle();
      chk($sformatf("v%0d_left", i), out_MEM_valid, 1'b0);
    end

    // ld.b with the response two cycles late.
    enter("t2", mk(1'b1, 5'd3, 1'b1, OP_B, 32'h0000_2003));
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("t2_wait%0d", c), MEM_to_ID_bus[37], 1'b1);
      chk($sformatf("t2_nowb%0d", c), MEM_to_WB_valid, 1'b0);
      chk($sformatf("t2_stall%0d", c), MEM_allowin, 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_BBCC;
    settle();
    chk("t2_wb_valid", MEM_to_WB_valid, 1'b1);
    chk("t2_wait_off", MEM_to_ID_bus[37], 1'b0);
    chk("t2_result", MEM_to_WB_bus[31:0], 32'hFFFF_FF80);
    chk("t2_fwd_data", MEM_to_ID_bus[31:0], 32'hFFFF_FF80);
    tick();
    data_sram_data_ok = 1'b0;

    // ld.h answered while WB is blocked; later rdata must not leak in.
    enter("t3", mk(1'b1, 5'd4, 1'b1, OP_H, 32'h0000_3002));
    WB_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_1234;
    settle();
    chk("t3_allowin0", MEM_allowin, 1'b0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0000_5555;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("t3_hold_valid%0d", c), MEM_to_WB_valid, 1'b1);
      chk($sformatf("t3_hold_result%0d", c), MEM_to_WB_bus[31:0], 32'hFFFF_80AA);
      chk($sformatf("t3_hold_wait%0d", c), MEM_to_ID_bus[37], 1'b0);
      tick();
    end
    WB_allowin = 1'b1;
    settle();
    chk("t3_result", MEM_to_WB_bus[31:0], 32'hFFFF_80AA);
    chk("t3_allowin1", MEM_allowin, 1'b1);
    tick();
    settle();
    chk("t3_left", out_MEM_valid, 1'b0);

    // Flush with a waiting load plus a new EXE request: two responses must be dropped.
    enter("t4a", mk(1'b1, 5'd5, 1'b1, OP_W, 32'h0000_4000));
    exec_flush = 1'b1; EXE_req_accepted = 1'b1;
    settle();
    chk("t4_flush_nowb", MEM_to_WB_valid, 1'b0);
    tick();
    exec_flush = 1'b0; EXE_req_accepted = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    enter("t4b", mk(1'b1, 5'd6, 1'b1, OP_W, 32'h0000_4004));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
    settle();
    chk("t4_drop2_nowb", MEM_to_WB_valid, 1'b0);
    chk("t4_drop2_wait", MEM_to_ID_bus[37], 1'b1);
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk("t4_idle_nowb", MEM_to_WB_valid, 1'b0);
    tick();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    settle();
    chk("t4_deliver_valid", MEM_to_WB_valid, 1'b1);
    chk("t4_deliver_result", MEM_to_WB_bus[31:0], 32'hCAFE_F00D);
    tick();
    data_sram_data_ok = 1'b0;
    settle();
    chk("t4_left", out_MEM_valid, 1'b0);

    // Flush coinciding with the load's own response: nothing to cancel.
    enter("t5a", mk(1'b1, 5'd8, 1'b1, OP_W, 32'h0000_5000));
    exec_flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    settle();
    chk("t5_flush_nowb", MEM_to_WB_valid, 1'b0);
    tick();
    exec_flush = 1'b0; data_sram_data_ok = 1'b0;
    settle();
    chk("t5_flushed", out_MEM_valid, 1'b0);
    enter("t5b", mk(1'b1, 5'd9, 1'b1, OP_W, 32'h0000_5004));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_0000;
    settle();
    chk("t5_next_valid", MEM_to_WB_valid, 1'b1);
    chk("t5_next_result", MEM_to_WB_bus[31:0], 32'h7777_0000);
    tick();
    data_sram_data_ok = 1'b0;

    // Reset while a load waits with a pending cancel count.
    enter("t6a", mk(1'b1, 5'd10, 1'b1, OP_W, 32'h0000_6000));
    exec_flush = 1'b1; EXE_req_accepted = 1'b1;
    tick();
    exec_flush = 1'b0; EXE_req_accepted = 1'b0;
    enter("t6b", mk(1'b1, 5'd11, 1'b1, OP_W, 32'h0000_6004));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("t6_mem_valid", out_MEM_valid, 1'b0);
    chk("t6_allowin", MEM_allowin, 1'b1);
    chk("t6_wb_valid", MEM_to_WB_valid, 1'b0);
    chk("t6_fwd_we", MEM_to_ID_bus[38], 1'b0);
    enter("t6c", mk(1'b1, 5'd12, 1'b1, OP_W, 32'h0000_6008));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3C3C_A5A5;
    settle();
    chk("t6_after_valid", MEM_to_WB_valid, 1'b1);
    chk("t6_after_result", MEM_to_WB_bus[31:0], 32'h3C3C_A5A5);
    tick();
    data_sram_data_ok = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
